// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with decode, registered result and iterative multiplier
//
// Purpose:
//   Decodes ALUOp/funct and executes and/or/add/sub in a single cycle.
//   MUL runs on a shift-add multiplier that takes several cycles.
//   The result is registered, and valid_o pulses for one cycle when it updates.
//   A valid/ready handshake feeds the pipeline stall. kill_i flushes in-flight work.
//
// Optional macro:
//   ALU_MUL_EARLY_TERM_EN - MUL finishes as soon as the remaining multiplier
//   bits are all zero. Results are the same with or without it.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   valid_i / ready_o       operation handshake; ready_o low while MUL is busy
//   kill_i                  abort in-flight MUL / drop the presented op
//   ALUOp_i, funct_i        operation select
//   data1_i, data2_i        operands A and B
//   result_o, zero_o        registered result and (result == 0)
//   valid_o                 one-cycle pulse when result_o/zero_o update
//   illegal_o               last accepted R-type funct was unsupported
//   ALUCtrl_o               code of last accepted op (000 and, 001 or, 010 add, 011 sub, 100 mul)

module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              kill_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic [2:0]        ALUCtrl_o
);

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b011;
  localparam logic [2:0] CTRL_MUL = 3'b100;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_valid;
  logic              r_illegal;
  logic [2:0]        r_ctrl;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  logic [2:0]        w_ctrl;
  logic              w_illegal;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_accept;
  logic [DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0] w_mplier_next;
  logic              w_last;

  assign ready_o  = (r_state == S_IDLE) && !rst_i;
  assign w_accept = valid_i && ready_o && !kill_i;

  // Unsupported R-type functs still execute as add.
  // They are flagged through illegal_o.
  always_comb begin
    w_ctrl    = CTRL_ADD;
    w_illegal = 1'b0;
    case (ALUOp_i)
      2'b00: w_ctrl = CTRL_ADD;
      2'b01: w_ctrl = CTRL_SUB;
      2'b11: w_ctrl = CTRL_OR;
      default: begin
        case (funct_i)
          6'b100100: w_ctrl = CTRL_AND;
          6'b100101: w_ctrl = CTRL_OR;
          6'b100000: w_ctrl = CTRL_ADD;
          6'b100010: w_ctrl = CTRL_SUB;
          6'b011000: w_ctrl = CTRL_MUL;
          default: begin
            w_ctrl    = CTRL_ADD;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Single-cycle datapath. MUL takes the iterative path, so it is not handled here.
  always_comb begin
    w_alu_res = data1_i + data2_i;
    case (w_ctrl)
      CTRL_AND: w_alu_res = data1_i & data2_i;
      CTRL_OR:  w_alu_res = data1_i | data2_i;
      CTRL_SUB: w_alu_res = data1_i - data2_i;
      default:  w_alu_res = data1_i + data2_i;
    endcase
  end

  // One shift-add step. mcand moves left while mplier moves right.
  // acc therefore collects the low DATA_W bits of the product.
  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_next = r_mplier >> 1;

`ifdef ALU_MUL_EARLY_TERM_EN
  // Once no multiplier bits remain, later steps cannot change acc.
  assign w_last = (r_cnt == CNT_W'(DATA_W - 1)) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_ctrl    <= CTRL_ADD;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_ctrl    <= w_ctrl;
          r_illegal <= w_illegal;
          if (w_ctrl == CTRL_MUL) begin
            r_acc    <= '0;
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end else begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
            r_valid  <= 1'b1;
          end
        end
      end else begin
        // A kill abandons the product.
        // result_o keeps the last completed value.
        if (kill_i) begin
          r_state <= S_IDLE;
        end else begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_valid  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
      end
    end
  end

  assign result_o  = r_result;
  assign zero_o    = r_zero;
  assign valid_o   = r_valid;
  assign illegal_o = r_illegal;
  assign ALUCtrl_o = r_ctrl;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit against a behavioural model

module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         kill;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         valid_o;
  logic         illegal_o;
  logic [2:0]   ctrl_o;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready_o), .kill_i(kill),
    .ALUOp_i(aluop), .funct_i(funct), .data1_i(a), .data2_i(b),
    .result_o(result_o), .zero_o(zero_o), .valid_o(valid_o),
    .illegal_o(illegal_o), .ALUCtrl_o(ctrl_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the decode table and plain arithmetic.
  function automatic void model_op(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] res, output logic [2:0] ctrl,
                                   output logic ill);
    ill = 1'b0;
    if (op == 2'b00)      begin res = x + y; ctrl = 3'b010; end
    else if (op == 2'b01) begin res = x - y; ctrl = 3'b011; end
    else if (op == 2'b11) begin res = x | y; ctrl = 3'b001; end
    else if (fn == 6'b100100) begin res = x & y; ctrl = 3'b000; end
    else if (fn == 6'b100101) begin res = x | y; ctrl = 3'b001; end
    else if (fn == 6'b100000) begin res = x + y; ctrl = 3'b010; end
    else if (fn == 6'b100010) begin res = x - y; ctrl = 3'b011; end
    else if (fn == 6'b011000) begin res = x * y; ctrl = 3'b100; end
    else begin res = x + y; ctrl = 3'b010; ill = 1'b1; end
  endfunction

  // Number of edges after the accept edge until the MUL completes.
  function automatic int mul_lat(input logic [W-1:0] y);
    int h = 0;
    for (int i = 0; i < W; i++) if (y[i]) h = i + 1;
`ifdef ALU_MUL_EARLY_TERM_EN
    return (h == 0) ? 1 : h;
`else
    return W;
`endif
  endfunction

  // Presents one op and waits for valid_o.
  // lat counts the edges after the accept edge (0 = valid right after accept).
  task automatic drive_and_wait(input logic [1:0] op, input logic [5:0] fn,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output int lat, output bit timed_out, output int ready_hi);
    aluop = op; funct = fn; a = x; b = y; valid = 1'b1;
    tick();
    valid = 1'b0;
    lat = 0; ready_hi = 0;
    while (!valid_o && lat < 200) begin
      if (ready_o) ready_hi++;
      tick();
      lat++;
    end
    timed_out = !valid_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; kill = 1'b0; aluop = 2'b00; funct = '0; a = '0; b = '0;
    tick(); tick();
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst got=%b exp=0", ready_o); end
    rst = 1'b0; #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (result_o !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++; if (zero_o !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", zero_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (illegal_o !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
    checks++; if (ctrl_o !== 3'b010) begin failures++; $display("FAIL reset_ctrl got=%b exp=010", ctrl_o); end
  endtask

  task automatic test_add();
    int lat; bit to; int rh;
    drive_and_wait(2'b10, 6'b100000, 32'd7, 32'd5, lat, to, rh);
    checks++; if (to || lat != 0) begin failures++; $display("FAIL add_latency got=%0d exp=0", lat); end
    checks++; if (result_o !== 32'd12) begin failures++; $display("FAIL add_result got=%h exp=c", result_o); end
    checks++; if (zero_o !== 1'b0 || ctrl_o !== 3'b010) begin failures++; $display("FAIL add_flags got zero=%b ctrl=%b exp zero=0 ctrl=010", zero_o, ctrl_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL add_pulse_width got=%b exp=0", valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   op_t [3];
    logic [5:0]   fn_t [3];
    logic [W-1:0] a_t  [3];
    logic [W-1:0] b_t  [3];
    logic [W-1:0] e_t  [3];
    op_t = '{2'b01, 2'b10, 2'b11};
    fn_t = '{6'b000000, 6'b100100, 6'b000000};
    a_t  = '{32'd5, 32'hF0F0, 32'h1};
    b_t  = '{32'd5, 32'h0FF0, 32'h2};
    e_t  = '{32'd0, 32'h00F0, 32'h3};
    for (int i = 0; i < 3; i++) begin
      aluop = op_t[i]; funct = fn_t[i]; a = a_t[i]; b = b_t[i]; valid = 1'b1;
      tick();
      checks++;
      if (valid_o !== 1'b1 || result_o !== e_t[i] || zero_o !== (e_t[i] == '0)) begin
        failures++;
        $display("FAIL b2b_%0d got valid=%b res=%h zero=%b exp valid=1 res=%h zero=%b",
                 i, valid_o, result_o, zero_o, e_t[i], (e_t[i] == '0));
      end
    end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_mul_hold();
    int n = 0; int rh = 0;
    aluop = 2'b10; funct = 6'b011000; a = 32'hFFFF_FFFF; b = 32'd3; valid = 1'b1;
    tick();
    // Keep a different op presented; it must wait for ready_o.
    aluop = 2'b00; a = 32'd1; b = 32'd1;
    while (!valid_o && n < 200) begin
      if (ready_o) rh++;
      tick();
      n++;
    end
    checks++; if (n != mul_lat(32'd3)) begin failures++; $display("FAIL mulhold_latency got=%0d exp=%0d", n, mul_lat(32'd3)); end
    checks++; if (rh != 0) begin failures++; $display("FAIL mulhold_ready_busy got=%0d exp=0", rh); end
    checks++; if (result_o !== 32'hFFFF_FFFD || ctrl_o !== 3'b100) begin failures++; $display("FAIL mulhold_result got=%h ctrl=%b exp=fffffffd ctrl=100", result_o, ctrl_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL mulhold_ready_done got=%b exp=1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || result_o !== 32'd2 || ctrl_o !== 3'b010) begin failures++; $display("FAIL mulhold_next got valid=%b res=%h ctrl=%b exp valid=1 res=2 ctrl=010", valid_o, result_o, ctrl_o); end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    int lat; bit to; int rh;
    drive_and_wait(2'b10, 6'b000000, 32'd2, 32'd3, lat, to, rh);
    checks++; if (to || result_o !== 32'd5 || illegal_o !== 1'b1 || ctrl_o !== 3'b010) begin failures++; $display("FAIL illegal_op got res=%h ill=%b ctrl=%b exp res=5 ill=1 ctrl=010", result_o, illegal_o, ctrl_o); end
    drive_and_wait(2'b00, 6'b000000, 32'd9, 32'd4, lat, to, rh);
    checks++; if (to || result_o !== 32'd13 || illegal_o !== 1'b0) begin failures++; $display("FAIL illegal_clear got res=%h ill=%b exp res=d ill=0", result_o, illegal_o); end
  endtask

  task automatic test_mul_latency();
    logic [W-1:0] x_t [5];
    logic [W-1:0] y_t [5];
    logic [W-1:0] er; logic [2:0] ec; logic ei;
    int lat; bit to; int rh;
    x_t = '{32'hFFFF_FFFF, 32'd9, 32'd9, 32'd5, 32'h1234_5678};
    y_t = '{32'd3, 32'd2, 32'd0, 32'h8000_0000, 32'h0001_0000};
    for (int i = 0; i < 5; i++) begin
      model_op(2'b10, 6'b011000, x_t[i], y_t[i], er, ec, ei);
      drive_and_wait(2'b10, 6'b011000, x_t[i], y_t[i], lat, to, rh);
      checks++; if (to || lat != mul_lat(y_t[i])) begin failures++; $display("FAIL mul_lat_%0d got=%0d exp=%0d", i, lat, mul_lat(y_t[i])); end
      checks++; if (result_o !== er || zero_o !== (er == '0) || ctrl_o !== 3'b100) begin failures++; $display("FAIL mul_res_%0d got res=%h zero=%b ctrl=%b exp res=%h zero=%b ctrl=100", i, result_o, zero_o, ctrl_o, er, (er == '0)); end
      checks++; if (rh != 0) begin failures++; $display("FAIL mul_busy_%0d got ready cycles=%0d exp=0", i, rh); end
    end
  endtask

  task automatic test_kill();
    int lat; bit to; int rh; int k; int early = 0;
    drive_and_wait(2'b00, 6'b000000, 32'd1, 32'd2, lat, to, rh);
    k = (mul_lat(32'd7) - 1 < 9) ? mul_lat(32'd7) - 1 : 9;
    aluop = 2'b10; funct = 6'b011000; a = 32'd6; b = 32'd7; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < k; i++) begin tick(); if (valid_o) early++; end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    if (valid_o) early++;
    tick();
    if (valid_o) early++;
    checks++; if (early != 0) begin failures++; $display("FAIL kill_no_valid got pulses=%0d exp=0", early); end
    checks++; if (result_o !== 32'd3 || zero_o !== 1'b0) begin failures++; $display("FAIL kill_result got res=%h zero=%b exp res=3 zero=0", result_o, zero_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL kill_ready got=%b exp=1", ready_o); end
    // Kill while idle drops the op.
    aluop = 2'b00; a = 32'd8; b = 32'd8; valid = 1'b1; kill = 1'b1;
    tick();
    valid = 1'b0; kill = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b0 || result_o !== 32'd3) begin failures++; $display("FAIL kill_idle got valid=%b res=%h exp valid=0 res=3", valid_o, result_o); end
    // Reset mid-MUL after setting illegal_o and a nonzero result.
    drive_and_wait(2'b10, 6'b111111, 32'd4, 32'd4, lat, to, rh);
    aluop = 2'b10; funct = 6'b011000; a = 32'd6; b = 32'd7; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < k; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (result_o !== '0 || zero_o !== 1'b0 || valid_o !== 1'b0 || illegal_o !== 1'b0 || ctrl_o !== 3'b010)
      begin failures++; $display("FAIL rst_mid_mul got res=%h zero=%b valid=%b ill=%b ctrl=%b exp all reset", result_o, zero_o, valid_o, illegal_o, ctrl_o); end
    rst = 1'b0; #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_mul_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_random();
    logic [5:0] legal [5];
    logic [1:0] op; logic [5:0] fn; logic [W-1:0] x, y, er, held; logic [2:0] ec; logic ei;
    int lat; bit to; int rh; int exp_lat;
    legal = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b011000};
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : legal[$urandom_range(0, 4)];
      x = $urandom;
      y = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 255)) : W'($urandom);
      if (i % 7 == 3) begin
        held = result_o;
        aluop = op; funct = fn; a = x; b = y; valid = 1'b1; kill = 1'b1;
        tick();
        valid = 1'b0; kill = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b0 || result_o !== held) begin failures++; $display("FAIL rnd_drop_%0d got valid=%b res=%h exp valid=0 res=%h", i, valid_o, result_o, held); end
      end
      model_op(op, fn, x, y, er, ec, ei);
      exp_lat = (ec == 3'b100) ? mul_lat(y) : 0;
      drive_and_wait(op, fn, x, y, lat, to, rh);
      checks++;
      if (to || lat != exp_lat || result_o !== er || zero_o !== (er == '0) || ctrl_o !== ec || illegal_o !== ei) begin
        failures++;
        $display("FAIL rnd_%0d op=%b fn=%b a=%h b=%h got lat=%0d res=%h zero=%b ctrl=%b ill=%b exp lat=%0d res=%h zero=%b ctrl=%b ill=%b",
                 i, op, fn, x, y, lat, result_o, zero_o, ctrl_o, illegal_o, exp_lat, er, (er == '0), ec, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul_hold();
    test_illegal();
    test_mul_latency();
    test_kill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp/funct, executes the operation, and registers the result.
- Adds an iterative shift-add multiplier, which makes MUL multi-cycle.
- Sits in the EX stage with a valid/ready handshake; ready_o drives the pipeline stall and kill_i flushes in-flight work.

Parameters:
DATA_W, 32, operand/result width (>=4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
valid_i  input  1  operation presented
ready_o  output  1  unit can accept an operation this cycle
kill_i  input  1  flush: abort in-flight MUL / drop the presented op
ALUOp_i  input  2  00 add, 01 sub, 10 R-type (use funct_i), 11 or
funct_i  input  6  R-type function field
data1_i  input  DATA_W  operand A
data2_i  input  DATA_W  operand B
result_o  output  DATA_W  registered result
zero_o  output  1  registered (result_o == 0)
valid_o  output  1  one-cycle pulse: result_o/zero_o updated
illegal_o  output  1  registered: last accepted R-type funct was unsupported
ALUCtrl_o  output  3  registered code of last accepted op: 000 and, 001 or, 010 add, 011 sub, 100 mul

Behaviour:
- Reset (rst_i=1 at an edge, overrides everything including an in-flight MUL):
  - state=IDLE; result_o=0, zero_o=0, valid_o=0, illegal_o=0, ALUCtrl_o=010.
  - ready_o is 1 in the first cycle after reset.
- Accept: valid_i && ready_o && !kill_i at a rising edge.
- Decode:
  - ALUOp 00 → add; 01 → sub; 11 → or.
  - ALUOp 10, funct_i: 100100 and, 100101 or, 100000 add, 100010 sub, 011000 mul.
  - ALUOp 10 with any other funct → executes as add, illegal_o=1.
  - Every other accept clears illegal_o.
- Arithmetic:
  - Modulo 2^DATA_W; no overflow flag.
  - sub = data1 − data2 (two's complement).
  - mul = low DATA_W bits of the unsigned product (equal to the signed low half).
- FSM states IDLE, MUL. ready_o = (state==IDLE) && !rst_i.
- IDLE, non-MUL accept:
  - At the same edge: result_o, zero_o, ALUCtrl_o, illegal_o load; valid_o=1 in the next cycle.
  - Latency 1; back-to-back accepts give consecutive valid_o pulses.
- IDLE, MUL accept:
  - Load acc=0, mcand=data1_i, mplier=data2_i, cnt=0; go to MUL.
  - ALUCtrl_o=100 at the same edge. result_o holds its old value.
- MUL, each edge:
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the edge where cnt==DATA_W−1: result_o=final acc, zero_o updated, state=IDLE, valid_o=1 next cycle.
  - Latency DATA_W cycles accept→valid_o; ready_o=0 throughout MUL.
- valid_o: high for exactly one cycle per completed op; 0 otherwise.
- result_o/zero_o hold between completions.
- kill_i:
  - In MUL: next state IDLE, no valid_o, result_o/zero_o unchanged.
  - In IDLE: the presented op is dropped (no accept, no valid_o).
  - kill_i does not cancel a valid_o pulse already scheduled from the previous edge.
- Inputs are sampled only at the accept edge; operand changes during MUL are ignored.

Optional Feature:
ALU_MUL_EARLY_TERM_EN
- Defined:
  - In MUL, when the post-shift mplier is all-zero, that edge completes exactly as the final iteration does (load result, IDLE, valid_o next).
  - MUL latency = max(1, index of the highest set bit of data2 + 1) cycles.
  - mul by 0 completes in 1 cycle with result 0, zero_o=1.
- Undefined: fixed DATA_W-cycle MUL latency regardless of operands.
- Results are identical either way.

Test Plan:
- Reset then ALUOp=10, funct=100000, 7+5 → valid_o 1 cycle later, result_o=12, zero_o=0, ALUCtrl_o=010, ready_o stays 1.
- Back-to-back: sub 5−5, then and 0xF0F0&0x0FF0, then ALUOp=11 0x1|0x2 → three consecutive valid_o; results 0 (zero_o=1), 0x00F0, 0x3.
- MUL 0xFFFFFFFF×3 (DATA_W=32, macro off) → ready_o=0 for 32 cycles, valid_o at cycle 32, result_o=0xFFFFFFFD; valid_i held during MUL is not accepted until ready_o=1.
- ALUOp=10, funct=000000, 2,3 → result_o=5, illegal_o=1; the next legal op clears illegal_o.
- MUL 6×7 with kill_i asserted in cycle 10 → no valid_o, result_o unchanged, ready_o=1 next cycle; repeat with rst_i instead → all outputs at reset values.
- Macro on: MUL 9×2 → valid_o 2 cycles after accept, result 18; MUL 9×0 → 1 cycle, result 0, zero_o=1.
